cmd_decoder: RTL and testbench

CMD_DECODER -- requirements
Module: cmd_decoder

---
 rtl/cmd_decoder_pkg.sv | 20 ++
 rtl/cmd_decoder_if.sv | 26 ++
 rtl/cmd_decoder_fifo.sv | 36 +++
 rtl/cmd_decoder.sv | 108 ++++++++++
 tb/tb_cmd_decoder.sv | 260 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/cmd_decoder_pkg.sv
// gfx_cmd_pkg: opcodes, primitive encodings, command word layout and FSM states for cmd_decoder.
package gfx_cmd_pkg;
  localparam int CMD_W   = 52;
  localparam int OP_W    = 4;
  localparam int FIELD_W = 12;
  localparam int COLOR_W = 24;
  localparam int OP_LSB  = 48;
  localparam int X0_LSB  = 36;
  localparam int Y0_LSB  = 24;
  localparam int X1_LSB  = 12;
  localparam int Y1_LSB  = 0;
  localparam logic [OP_W-1:0] OPC_NOP       = 4'h0;
  localparam logic [OP_W-1:0] OPC_SET_COLOR = 4'h1;
  localparam logic [OP_W-1:0] OPC_PIXEL     = 4'h2;
  localparam logic [OP_W-1:0] OPC_LINE      = 4'h3;
  localparam logic [OP_W-1:0] OPC_RECT      = 4'h4;
  localparam logic [OP_W-1:0] OPC_CLEAR     = 4'h5;
  typedef enum logic [2:0] {PRIM_PIXEL, PRIM_LINE, PRIM_RECT, PRIM_CLEAR} prim_op_e;
  typedef enum logic [1:0] {S_IDLE, S_DECODE, S_ISSUE} state_e;
endpackage

// File: rtl/cmd_decoder_if.sv
// cmd_decoder_if: command input and primitive output handshakes of cmd_decoder.
// Ports: cmd_valid/cmd_ready/command (upstream), prim_valid/prim_ready/prim_op/
// prim_x0/prim_y0/prim_x1/prim_y1/prim_color (downstream).
// slave = decoder side, master = the block driving commands and consuming primitives.
interface cmd_decoder_if #(parameter int COORD_W = 12);
  import gfx_cmd_pkg::*;
  logic               cmd_valid;
  logic               cmd_ready;
  logic [CMD_W-1:0]   command;
  logic               prim_valid;
  logic               prim_ready;
  logic [2:0]         prim_op;
  logic [COORD_W-1:0] prim_x0;
  logic [COORD_W-1:0] prim_y0;
  logic [COORD_W-1:0] prim_x1;
  logic [COORD_W-1:0] prim_y1;
  logic [COLOR_W-1:0] prim_color;
  modport master (
    output cmd_valid, command, prim_ready,
    input  cmd_ready, prim_valid, prim_op, prim_x0, prim_y0, prim_x1, prim_y1, prim_color
  );
  modport slave (
    input  cmd_valid, command, prim_ready,
    output cmd_ready, prim_valid, prim_op, prim_x0, prim_y0, prim_x1, prim_y1, prim_color
  );
endinterface

// File: rtl/cmd_decoder_fifo.sv
// cmd_fifo: command word buffer with registered storage and full/empty flags.
// Ports: clk, rst_ (async active-low), push/wdata, pop/rdata, full, empty.
// DEPTH must be a power of two; pointers carry one extra wrap bit.
module cmd_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 52
) (
  input  logic             clk,
  input  logic             rst_,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);
  localparam int AW = $clog2(DEPTH);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0] wp, rp;
  logic do_push, do_pop;
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign empty   = wp == rp;
  assign full    = (wp[AW] != rp[AW]) && (wp[AW-1:0] == rp[AW-1:0]);
  assign rdata   = mem[rp[AW-1:0]];
  always_ff @(posedge clk or negedge rst_)
    if (!rst_) begin
      wp <= '0;
      rp <= '0;
    end else begin
      if (do_push) wp <= wp + 1'b1;
      if (do_pop) rp <= rp + 1'b1;
    end
  always_ff @(posedge clk)
    if (do_push) mem[wp[AW-1:0]] <= wdata;
endmodule

// File: rtl/cmd_decoder.sv
// cmd_decoder: buffers 52-bit graphics commands and issues decoded primitives.
// Ports: clk, rst_ (async active-low), bus (cmd_decoder_if.slave: command in,
// primitive out), busy (FIFO non-empty or primitive in flight), err_count.
// Optional macro CMD_DECODER_ERR_CNT_EN enables the saturating illegal-opcode counter;
// without it err_count is tied to 0.
module cmd_decoder
  import gfx_cmd_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int COORD_W    = 12
) (
  input  logic             clk,
  input  logic             rst_,
  cmd_decoder_if.slave     bus,
  output logic             busy,
  output logic [7:0]       err_count
);
  state_e state, state_nx;
  logic full, empty, pop;
  logic [CMD_W-1:0] rdata, cur;
  logic [OP_W-1:0] opc;
  logic [FIELD_W-1:0] fx0, fy0, fx1, fy1, nx0, ny0, nx1, ny1;
  logic is_prim, is_pixel, is_rect, is_clear;
  logic [2:0] op_q;
  logic [COORD_W-1:0] x0_q, y0_q, x1_q, y1_q;
  logic [COLOR_W-1:0] color_q, pcolor_q;
  cmd_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(CMD_W)) u_fifo (
    .clk   (clk),
    .rst_  (rst_),
    .push  (bus.cmd_valid && bus.cmd_ready),
    .wdata (bus.command),
    .pop   (pop),
    .rdata (rdata),
    .full  (full),
    .empty (empty)
  );
  assign bus.cmd_ready  = !full;
  assign bus.prim_valid = state == S_ISSUE;
  assign bus.prim_op    = op_q;
  assign bus.prim_x0    = x0_q;
  assign bus.prim_y0    = y0_q;
  assign bus.prim_x1    = x1_q;
  assign bus.prim_y1    = y1_q;
  assign bus.prim_color = pcolor_q;
  assign busy           = !empty || state != S_IDLE;
  assign opc      = cur[OP_LSB +: OP_W];
  assign fx0      = cur[X0_LSB +: FIELD_W];
  assign fy0      = cur[Y0_LSB +: FIELD_W];
  assign fx1      = cur[X1_LSB +: FIELD_W];
  assign fy1      = cur[Y1_LSB +: FIELD_W];
  assign is_prim  = opc >= OPC_PIXEL && opc <= OPC_CLEAR;
  assign is_pixel = opc == OPC_PIXEL;
  assign is_rect  = opc == OPC_RECT;
  assign is_clear = opc == OPC_CLEAR;
  // RECT corners are normalised to min/max; PIXEL mirrors its single point into x1/y1.
  always_comb begin
    nx0 = is_clear ? '0 : (is_rect && fx1 < fx0) ? fx1 : fx0;
    ny0 = is_clear ? '0 : (is_rect && fy1 < fy0) ? fy1 : fy0;
    nx1 = is_clear ? '0 : is_pixel ? fx0 : (is_rect && fx1 < fx0) ? fx0 : fx1;
    ny1 = is_clear ? '0 : is_pixel ? fy0 : (is_rect && fy1 < fy0) ? fy0 : fy1;
  end
  always_ff @(posedge clk or negedge rst_)
    if (!rst_) state <= S_IDLE;
    else state <= state_nx;
  always_comb begin
    pop      = state == S_IDLE && !empty;
    state_nx = state;
    case (state)
      S_IDLE:   state_nx = empty ? S_IDLE : S_DECODE;
      S_DECODE: state_nx = is_prim ? S_ISSUE : S_IDLE;
      S_ISSUE:  state_nx = bus.prim_ready ? S_IDLE : S_ISSUE;
      default:  state_nx = S_IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_)
    if (!rst_) cur <= '0;
    else if (pop) cur <= rdata;
  // Outputs only load in DECODE, so they hold steady for the whole ISSUE phase.
  always_ff @(posedge clk or negedge rst_)
    if (!rst_) begin
      op_q     <= PRIM_PIXEL;
      x0_q     <= '0;
      y0_q     <= '0;
      x1_q     <= '0;
      y1_q     <= '0;
      color_q  <= '1;
      pcolor_q <= '1;
    end else if (state == S_DECODE) begin
      if (opc == OPC_SET_COLOR) color_q <= cur[COLOR_W-1:0];
      if (is_prim) begin
        op_q     <= 3'(opc - OPC_PIXEL);
        x0_q     <= COORD_W'(nx0);
        y0_q     <= COORD_W'(ny0);
        x1_q     <= COORD_W'(nx1);
        y1_q     <= COORD_W'(ny1);
        pcolor_q <= color_q;
      end
    end
`ifdef CMD_DECODER_ERR_CNT_EN
  logic [7:0] err_q;
  always_ff @(posedge clk or negedge rst_)
    if (!rst_) err_q <= '0;
    else if (state == S_DECODE && opc > OPC_CLEAR && err_q != 8'hFF) err_q <= err_q + 1'b1;
  assign err_count = err_q;
`else
  assign err_count = '0;
`endif
endmodule

// File: tb/tb_cmd_decoder.sv
// tb_cmd_decoder: directed and LFSR-driven self-checking bench for cmd_decoder.
module tb_cmd_decoder;
  import gfx_cmd_pkg::*;
  typedef struct packed {
    logic [2:0]  op;
    logic [11:0] x0, y0, x1, y1;
    logic [23:0] color;
  } prim_t;
`ifdef CMD_DECODER_ERR_CNT_EN
  localparam logic [7:0] ERR_SMALL = 8'd2;
  localparam logic [7:0] ERR_BIG   = 8'd255;
`else
  localparam logic [7:0] ERR_SMALL = 8'd0;
  localparam logic [7:0] ERR_BIG   = 8'd0;
`endif
  logic clk = 1'b0;
  logic rst_ = 1'b0;
  logic busy;
  logic [7:0] err_count;
  int checks = 0;
  int errors = 0;
  logic [23:0] model_color;
  prim_t exp_q[$];
  cmd_decoder_if #(.COORD_W(12)) bus ();
  cmd_decoder #(.FIFO_DEPTH(4), .COORD_W(12)) dut (
    .clk       (clk),
    .rst_      (rst_),
    .bus       (bus),
    .busy      (busy),
    .err_count (err_count)
  );
  always #5 clk = ~clk;

  function automatic logic [51:0] mk(input logic [3:0] op, input logic [11:0] a, b, c, d);
    return {op, a, b, c, d};
  endfunction

  function automatic prim_t cur_prim();
    return {bus.prim_op, bus.prim_x0, bus.prim_y0, bus.prim_x1, bus.prim_y1, bus.prim_color};
  endfunction

  // Reference behaviour: returns 1 and the expected primitive for drawing opcodes.
  function automatic bit model_prim(input logic [51:0] w, inout logic [23:0] col, output prim_t p);
    logic [11:0] a, b, c, d;
    a = w[47:36]; b = w[35:24]; c = w[23:12]; d = w[11:0];
    p = '0;
    p.color = col;
    case (w[51:48])
      4'h1: begin col = w[23:0]; return 1'b0; end
      4'h2: begin p.op = 3'd0; p.x0 = a; p.y0 = b; p.x1 = a; p.y1 = b; return 1'b1; end
      4'h3: begin p.op = 3'd1; p.x0 = a; p.y0 = b; p.x1 = c; p.y1 = d; return 1'b1; end
      4'h4: begin
        p.op = 3'd2;
        p.x0 = (a < c) ? a : c; p.x1 = (a < c) ? c : a;
        p.y0 = (b < d) ? b : d; p.y1 = (b < d) ? d : b;
        return 1'b1;
      end
      4'h5: begin p.op = 3'd3; return 1'b1; end
      default: return 1'b0;
    endcase
  endfunction

  task automatic do_reset();
    rst_ = 1'b0;
    bus.cmd_valid = 1'b0;
    bus.command = '0;
    bus.prim_ready = 1'b0;
    repeat (2) @(negedge clk);
    rst_ = 1'b1;
    @(negedge clk);
    model_color = 24'hFFFFFF;
  endtask

  // Offers a word until accepted; returns at the negedge after the accepting edge.
  task automatic push(input logic [51:0] w);
    bit ok = 1'b0;
    bus.cmd_valid = 1'b1;
    bus.command = w;
    for (int i = 0; i < 200 && !ok; i++) begin
      ok = bus.cmd_ready;
      @(negedge clk);
    end
    bus.cmd_valid = 1'b0;
    checks++;
    if (!ok) begin errors++; $display("FAIL push_accept got timeout want accepted word %h", w); end
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (bus.cmd_ready !== 1'b1) begin errors++; $display("FAIL reset_cmd_ready got %b want 1", bus.cmd_ready); end
    checks++; if (bus.prim_valid !== 1'b0) begin errors++; $display("FAIL reset_prim_valid got %b want 0", bus.prim_valid); end
    checks++; if (bus.prim_op !== 3'd0) begin errors++; $display("FAIL reset_prim_op got %0d want 0", bus.prim_op); end
    checks++; if ({bus.prim_x0, bus.prim_y0, bus.prim_x1, bus.prim_y1} !== 48'd0) begin errors++; $display("FAIL reset_coords got %h want 0", {bus.prim_x0, bus.prim_y0, bus.prim_x1, bus.prim_y1}); end
    checks++; if (bus.prim_color !== 24'hFFFFFF) begin errors++; $display("FAIL reset_color got %h want ffffff", bus.prim_color); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
    checks++; if (err_count !== 8'd0) begin errors++; $display("FAIL reset_err_count got %0d want 0", err_count); end
  endtask

  task automatic test_pixel();
    prim_t e;
    do_reset();
    bus.prim_ready = 1'b1;
    push(52'h1_000_000_123456);
    repeat (4) @(negedge clk);
    push(mk(4'h2, 12'd5, 12'd7, 12'd0, 12'd0));
    checks++; if (bus.prim_valid !== 1'b0) begin errors++; $display("FAIL pixel_lat_c1 got %b want 0", bus.prim_valid); end
    @(negedge clk);
    checks++; if (bus.prim_valid !== 1'b0) begin errors++; $display("FAIL pixel_lat_c2 got %b want 0", bus.prim_valid); end
    @(negedge clk);
    checks++; if (bus.prim_valid !== 1'b1) begin errors++; $display("FAIL pixel_lat_c3 got %b want 1", bus.prim_valid); end
    e = {3'd0, 12'd5, 12'd7, 12'd5, 12'd7, 24'h123456};
    checks++; if (cur_prim() !== e) begin errors++; $display("FAIL pixel_fields got %h want %h", cur_prim(), e); end
    @(negedge clk);
    checks++; if (bus.prim_valid !== 1'b0) begin errors++; $display("FAIL pixel_valid_fall got %b want 0", bus.prim_valid); end
  endtask

  task automatic test_rect_clear();
    prim_t e;
    do_reset();
    push(mk(4'h4, 12'd100, 12'd50, 12'd10, 12'd200));
    for (int i = 0; i < 20 && !bus.prim_valid; i++) @(negedge clk);
    e = {3'd2, 12'd10, 12'd50, 12'd100, 12'd200, 24'hFFFFFF};
    checks++; if (bus.prim_valid !== 1'b1) begin errors++; $display("FAIL rect_valid got %b want 1", bus.prim_valid); end
    checks++; if (cur_prim() !== e) begin errors++; $display("FAIL rect_fields got %h want %h", cur_prim(), e); end
    bus.prim_ready = 1'b1;
    @(negedge clk);
    push(mk(4'h5, 12'd9, 12'd8, 12'd7, 12'd6));
    for (int i = 0; i < 20 && !bus.prim_valid; i++) @(negedge clk);
    e = {3'd3, 48'd0, 24'hFFFFFF};
    checks++; if (cur_prim() !== e || bus.prim_valid !== 1'b1) begin errors++; $display("FAIL clear_fields got %b/%h want 1/%h", bus.prim_valid, cur_prim(), e); end
  endtask

  task automatic test_backpressure();
    prim_t exp_l[6];
    prim_t first;
    logic [51:0] w;
    int n = 0;
    bit pend;
    do_reset();
    for (int i = 0; i < 6; i++) begin
      w = mk(4'h3, 12'(10 * i + 1), 12'(10 * i + 2), 12'(10 * i + 3), 12'(10 * i + 4));
      void'(model_prim(w, model_color, exp_l[i]));
      if (i < 5) push(w);
    end
    first = cur_prim();
    checks++; if (bus.cmd_ready !== 1'b0) begin errors++; $display("FAIL bp_full got cmd_ready %b want 0", bus.cmd_ready); end
    checks++; if (first !== exp_l[0] || bus.prim_valid !== 1'b1) begin errors++; $display("FAIL bp_head got %b/%h want 1/%h", bus.prim_valid, first, exp_l[0]); end
    bus.cmd_valid = 1'b1;
    bus.command = w;
    repeat (3) @(negedge clk);
    checks++; if (cur_prim() !== exp_l[0] || bus.cmd_ready !== 1'b0) begin errors++; $display("FAIL bp_stable got %h ready %b want %h ready 0", cur_prim(), bus.cmd_ready, exp_l[0]); end
    bus.prim_ready = 1'b1;
    for (int c = 0; c < 100 && n < 6; c++) begin
      if (bus.prim_valid) begin
        checks++;
        if (cur_prim() !== exp_l[n]) begin errors++; $display("FAIL bp_order_%0d got %h want %h", n, cur_prim(), exp_l[n]); end
        n++;
      end
      pend = bus.cmd_valid && bus.cmd_ready;
      @(negedge clk);
      if (pend) bus.cmd_valid = 1'b0;
    end
    checks++; if (n != 6) begin errors++; $display("FAIL bp_count got %0d want 6", n); end
  endtask

  task automatic test_illegal();
    bit seen = 1'b0;
    do_reset();
    bus.prim_ready = 1'b1;
    push(mk(4'hA, 12'd1, 12'd2, 12'd3, 12'd4));
    push(mk(4'hF, 12'd1, 12'd2, 12'd3, 12'd4));
    push(mk(4'h0, 12'd1, 12'd2, 12'd3, 12'd4));
    for (int i = 0; i < 8; i++) begin
      if (bus.prim_valid) seen = 1'b1;
      @(negedge clk);
    end
    checks++; if (seen) begin errors++; $display("FAIL illegal_no_prim got prim_valid 1 want 0"); end
    checks++; if (err_count !== ERR_SMALL) begin errors++; $display("FAIL illegal_err2 got %0d want %0d", err_count, ERR_SMALL); end
    for (int i = 0; i < 300; i++) push(mk(4'(6 + i % 10), 12'(i), 12'd0, 12'd0, 12'd0));
    repeat (4) @(negedge clk);
    checks++; if (err_count !== ERR_BIG) begin errors++; $display("FAIL illegal_err_sat got %0d want %0d", err_count, ERR_BIG); end
  endtask

  task automatic test_reset_mid_issue();
    bit seen = 1'b0;
    do_reset();
    for (int i = 0; i < 4; i++) push(mk(4'h3, 12'(i + 1), 12'd2, 12'd3, 12'd4));
    checks++; if (bus.prim_valid !== 1'b1 || busy !== 1'b1) begin errors++; $display("FAIL rmi_pre got valid %b busy %b want 1 1", bus.prim_valid, busy); end
    #2 rst_ = 1'b0;
    #1;
    checks++; if (bus.prim_valid !== 1'b0) begin errors++; $display("FAIL rmi_valid got %b want 0", bus.prim_valid); end
    checks++; if (bus.cmd_ready !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL rmi_fifo got ready %b busy %b want 1 0", bus.cmd_ready, busy); end
    @(negedge clk);
    rst_ = 1'b1;
    bus.prim_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (bus.prim_valid || busy) seen = 1'b1;
    end
    checks++; if (seen) begin errors++; $display("FAIL rmi_after got activity want none"); end
  endtask

  task automatic test_random();
    logic [51:0] lfsr = 52'hA5A5_1234_5678_9;
    bit done = 1'b0;
    bit stall = 1'b0;
    prim_t held, e, p;
    int cyc = 0;
    do_reset();
    fork
      begin
        for (int n = 0; n < 10000; n++) begin
          for (int s = 0; s < 16; s++) lfsr = {lfsr[50:0], lfsr[51] ^ lfsr[48]};
          push(lfsr);
          if (model_prim(lfsr, model_color, p)) exp_q.push_back(p);
        end
        done = 1'b1;
      end
      begin
        while (!(done && exp_q.size() == 0 && !busy) && cyc < 60000) begin
          bus.prim_ready = $urandom_range(3) != 0;
          if (stall) begin
            checks++;
            if (bus.prim_valid !== 1'b1 || cur_prim() !== held) begin errors++; $display("FAIL rnd_stable got %b/%h want 1/%h", bus.prim_valid, cur_prim(), held); end
          end
          stall = 1'b0;
          if (bus.prim_valid && bus.prim_ready) begin
            checks++;
            if (exp_q.size() == 0) begin errors++; $display("FAIL rnd_extra got %h want none", cur_prim()); end
            else begin
              e = exp_q.pop_front();
              if (cur_prim() !== e) begin errors++; $display("FAIL rnd_prim got %h want %h", cur_prim(), e); end
            end
          end else if (bus.prim_valid) begin
            stall = 1'b1;
            held = cur_prim();
          end
          @(negedge clk);
          cyc++;
        end
      end
    join
    checks++; if (exp_q.size() != 0 || busy) begin errors++; $display("FAIL rnd_drain got %0d pending busy %b want 0 0", exp_q.size(), busy); end
  endtask

  initial begin
    bus.cmd_valid = 1'b0;
    bus.command = '0;
    bus.prim_ready = 1'b0;
    test_reset();
    test_pixel();
    test_rect_clear();
    test_backpressure();
    test_illegal();
    test_reset_mid_issue();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
